osd_settings_ctrl: RTL

- Configuration controller between commTransceiver and the video/clocking datapath.
- Turns decoded controller packets into navigation of a 4-item settings menu while the OSD is active, and keeps an editable shadow copy of the settings.
- Commits the shadow copy to the live configuration outputs (colorMode, framerate, smoothing, grid) only at a frame boundary.
- Rate-limits framerate changes so the MMCM DRP reconfiguration can complete and relock before another switch.

---
 rtl/osd_settings_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/osd_settings_ctrl.sv
// OSD settings controller: menu navigation over an editable shadow config,
// frame-aligned commit to the live outputs, and framerate-change lockout.
module osd_settings_ctrl #(
  parameter int unsigned REPEAT_DELAY = 30,
  parameter int unsigned REPEAT_RATE  = 6,
  parameter int unsigned FR_LOCKOUT   = 120
) (
  input  logic       pxlClk,
  input  logic       rst,
  input  logic [5:0] controller,
  input  logic       controllerRXValid,
  input  logic       osdActive,
  input  logic       newFrame,
  output logic [1:0] cursor,
  output logic [4:0] shadowCfg,
  output logic       colorMode,
  output logic       framerate,
  output logic [1:0] smooth,
  output logic       grid,
  output logic       commitPending,
  output logic       frLocked
);

  localparam int unsigned BTN_W  = 6;
  localparam int unsigned DIR_W  = 4;
  localparam int unsigned HOLD_W = 9;
  localparam int unsigned LOCK_W = 8;

  typedef struct packed {
    logic       grid;
    logic [1:0] smooth;
    logic       framerate;
    logic       color_mode;
  } cfg_t;

  typedef enum logic [1:0] {ST_CLOSED, ST_OPEN, ST_COMMIT} state_t;

  logic [BTN_W-1:0]  btn, btn_prev, evt;
  logic              rx_d, osd_prev;
  logic [DIR_W-1:0]  rep_pulse;
  logic [HOLD_W-1:0] hold_cnt [DIR_W];
  logic [LOCK_W-1:0] lock_cnt;
  logic              fr_locked, fr_load;
  state_t            state, state_d;
  logic [1:0]        cursor_q, cursor_d;
  cfg_t              shadow_q, shadow_d, live_q, live_d;
  logic              pend_q, pend_d;

  // Button latch; edges are judged one cycle after the strobe.
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      btn      <= '0;
      btn_prev <= '0;
      rx_d     <= 1'b0;
      osd_prev <= 1'b0;
    end else begin
      rx_d     <= controllerRXValid;
      osd_prev <= osdActive;
      if (controllerRXValid) begin
        btn      <= controller;
        btn_prev <= btn;
      end
    end
  end

  // Frame-based hold counters; after the first repeat they cycle between
  // REPEAT_DELAY and REPEAT_DELAY+REPEAT_RATE so they never overflow.
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      for (int i = 0; i < int'(DIR_W); i++) hold_cnt[i] <= '0;
      rep_pulse <= '0;
    end else begin
      rep_pulse <= '0;
      for (int i = 0; i < int'(DIR_W); i++) begin
        if (!btn[i]) begin
          hold_cnt[i] <= '0;
        end else if (newFrame) begin
          if (hold_cnt[i] + HOLD_W'(1) == HOLD_W'(REPEAT_DELAY + REPEAT_RATE)) begin
            hold_cnt[i]  <= HOLD_W'(REPEAT_DELAY);
            rep_pulse[i] <= 1'b1;
          end else begin
            hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
            if (hold_cnt[i] + HOLD_W'(1) == HOLD_W'(REPEAT_DELAY)) rep_pulse[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign evt     = (rx_d ? (btn & ~btn_prev) : '0) | {2'b00, rep_pulse};
  assign fr_load = (state == ST_COMMIT) && newFrame &&
                   (shadow_q.framerate != live_q.framerate);

  // Framerate lockout, loaded by a committed framerate change.
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      lock_cnt  <= '0;
      fr_locked <= 1'b0;
    end else if (fr_load) begin
      lock_cnt  <= LOCK_W'(FR_LOCKOUT);
      fr_locked <= 1'b1;
    end else if (newFrame && lock_cnt != '0) begin
      lock_cnt <= lock_cnt - LOCK_W'(1);
      if (lock_cnt == LOCK_W'(1)) fr_locked <= 1'b0;
    end
  end

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      state    <= ST_CLOSED;
      cursor_q <= '0;
      shadow_q <= '0;
      live_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      state    <= state_d;
      cursor_q <= cursor_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
      pend_q   <= pend_d;
    end
  end

  // Priority among events: B > A > up > down > left > right.
  always_comb begin
    state_d  = state;
    cursor_d = cursor_q;
    shadow_d = shadow_q;
    live_d   = live_q;
    pend_d   = pend_q;
    unique case (state)
      ST_CLOSED: begin
        shadow_d = live_q;
        if (osdActive && !osd_prev) begin
          state_d  = ST_OPEN;
          cursor_d = '0;
        end
      end
      ST_OPEN: begin
        if (!osdActive) begin
          shadow_d = live_q;
          state_d  = ST_CLOSED;
        end else if (evt[5]) begin
          shadow_d = live_q;
        end else if (evt[4]) begin
          state_d = ST_COMMIT;
          pend_d  = 1'b1;
        end else if (evt[0]) begin
          cursor_d = cursor_q - 2'd1;
        end else if (evt[1]) begin
          cursor_d = cursor_q + 2'd1;
        end else if (evt[2] || evt[3]) begin
          unique case (cursor_q)
            2'd0: shadow_d.color_mode = ~shadow_q.color_mode;
            2'd1: if (!fr_locked) shadow_d.framerate = ~shadow_q.framerate;
            2'd2: begin
              if (evt[2]) begin
                if (shadow_q.smooth != 2'd0) shadow_d.smooth = shadow_q.smooth - 2'd1;
              end else if (shadow_q.smooth < 2'd2) begin
                shadow_d.smooth = shadow_q.smooth + 2'd1;
              end
            end
            default: shadow_d.grid = ~shadow_q.grid;
          endcase
        end
      end
      ST_COMMIT: begin
        if (newFrame) begin
          live_d  = shadow_q;
          pend_d  = 1'b0;
          state_d = osdActive ? ST_OPEN : ST_CLOSED;
        end
      end
      default: state_d = ST_CLOSED;
    endcase
  end

  assign cursor        = cursor_q;
  assign shadowCfg     = shadow_q;
  assign colorMode     = live_q.color_mode;
  assign framerate     = live_q.framerate;
  assign smooth        = live_q.smooth;
  assign grid          = live_q.grid;
  assign commitPending = pend_q;
  assign frLocked      = fr_locked;

endmodule
